// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//
// Purpose:
//   Items shared by the bit-serial adder and its bench-facing users: the
//   default operand width, the FSM state encoding and a couple of small
//   helpers. No ports; this is a package.
//
// Contents:
//   DEFAULT_WIDTH   default operand/sum width of serial_adder
//   state_t         FSM states ST_IDLE=0, ST_RUN=1, ST_DONE=2 (3 unused)
//   is_known_state  true for the three encodings the FSM actually uses
//   cnt_last        terminal value of the per-bit counter for a width
//
// Configuration macro: none here (see serial_adder.sv for
// SERIAL_ADDER_SUB_EN).
// ---------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Encoding 2'd3 is never entered on purpose; the FSM treats it as IDLE so
    // that a corrupted state register recovers on the next edge.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_known_state(input state_t s);
        return (s == ST_IDLE) || (s == ST_RUN) || (s == ST_DONE);
    endfunction

    // The counter starts at 0 on acceptance, so the last bit is processed
    // while the counter equals width-1.
    function automatic int cnt_last(input int width);
        return width - 1;
    endfunction

endpackage : serial_adder_pkg

// File: rtl/one_bit_adder.sv
// ---------------------------------------------------------------------------
// one_bit_adder
//
// Purpose:
//   Purely combinational full adder cell. serial_adder reuses a single
//   instance of it for every bit position of the operands.
//
// Ports:
//   a       input   1  operand bit A
//   b       input   1  operand bit B
//   c_in    input   1  carry into this bit
//   sum     output  1  a ^ b ^ c_in
//   c_out   output  1  majority(a, b, c_in)
// ---------------------------------------------------------------------------
module one_bit_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    always_comb begin
        sum   = a ^ b ^ c_in;
        c_out = (a & b) | (a & c_in) | (b & c_in);
    end

endmodule : one_bit_adder

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Purpose:
//   Bit-serial WIDTH-bit adder. Operands are captured over an in_valid /
//   in_ready handshake, then one bit per clock (LSB first) is pushed through
//   a single one_bit_adder with the carry held in a flip-flop. After WIDTH
//   cycles the full sum and the final carry are presented over an
//   out_valid / out_ready handshake and held until the consumer takes them.
//   Overflow is not an error: sum wraps and the carry shows up on c_out.
//
// Parameters:
//   WIDTH   operand and sum width (>= 2), default 8
//   CNT_W   bit counter width, derived as $clog2(WIDTH)
//
// Ports:
//   clk        input   1      rising-edge clock
//   rst_n      input   1      asynchronous active-low reset
//   in_valid   input   1      operands a, b, c_in presented
//   in_ready   output  1      operands can be accepted (IDLE only)
//   a          input   WIDTH  operand A
//   b          input   WIDTH  operand B
//   c_in       input   1      initial carry-in
//   sub        input   1      (SERIAL_ADDER_SUB_EN only) compute a - b
//   out_valid  output  1      sum and c_out are valid (DONE only)
//   out_ready  input   1      consumer accepts the result
//   sum        output  WIDTH  (a + b + c_in) mod 2^WIDTH
//   c_out      output  1      carry out of bit WIDTH-1
//   busy       output  1      a computation is in progress (RUN only)
//
// Configuration macro:
//   SERIAL_ADDER_SUB_EN  when defined, adds the sub port. With sub=1 the
//                        block computes a - b (two's complement: ~b plus a
//                        forced carry-in of 1, c_in ignored) and c_out=1
//                        means no borrow. Undefined: addition only.
// ---------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(cnt_last(WIDTH));

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic             cell_sum;
    logic             cell_c_out;
    logic [WIDTH-1:0] sum_next;

    // Values loaded into the B shift register and the carry flop when
    // operands are accepted. Subtraction is a + ~b + 1, so it only changes
    // what gets loaded; the per-bit datapath is the same for both modes.
`ifdef SERIAL_ADDER_SUB_EN
    always_comb begin
        b_load     = b;
        carry_load = c_in;
        if (sub) begin
            b_load     = ~b;
            carry_load = 1'b1;
        end
    end
`else
    always_comb begin
        b_load     = b;
        carry_load = c_in;
    end
`endif

    // The single full-adder cell always looks at the current LSBs and the
    // stored carry; its outputs are only consumed in RUN.
    one_bit_adder u_cell (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c_in  (carry),
        .sum   (cell_sum),
        .c_out (cell_c_out)
    );

    // Sum bits enter at the MSB and move right, so after WIDTH shifts the
    // first (LSB) result bit has reached position 0.
    always_comb begin
        sum_next = {cell_sum, sum_sr[WIDTH-1:1]};
    end

    // Control FSM and datapath registers. The handshake/status outputs are
    // registered alongside the state so that none of them has a
    // combinational path from any input. sum/c_out are only written when the
    // last bit completes, so they stay stable throughout DONE regardless of
    // how long out_ready is held low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sr     <= a;
                        b_sr     <= b_load;
                        carry    <= carry_load;
                        cnt      <= '0;
                        state    <= ST_RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                ST_RUN: begin
                    sum_sr <= sum_next;
                    carry  <= cell_c_out;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        sum       <= sum_next;
                        c_out     <= cell_c_out;
                        state     <= ST_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    // Unused encoding behaves as IDLE and is cleaned up.
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Purpose:
//   Self-checking bench for serial_adder (WIDTH=8). A transaction-level model
//   (cycle countdown plus integer arithmetic) predicts the handshake outputs
//   and the result on every cycle; directed transactions add hand-computed
//   literal expectations. Building with SERIAL_ADDER_SUB_EN defined also
//   exercises the subtract mode.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             c_in = 1'b0;
    logic             sub_in = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;

    int n_total = 0;
    int n_pass  = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // One comparison: bumps the counters and reports a failure line.
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Arithmetic reference: full-width sum including the carry bit.
    function automatic logic [WIDTH:0] model_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                 input logic ci, input logic s);
        if (s) return {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    endfunction

    // Transaction model: after acceptance the result appears WIDTH edges
    // later and stays until out_ready is seen at an edge.
    int               m_left = 0;
    bit               m_done = 1'b0;
    logic [WIDTH-1:0] m_sum  = '0;
    logic             m_cout = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
        end else if (m_done) begin
            if (out_ready) m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else if (in_valid) begin
            {m_cout, m_sum} = model_add(a, b, c_in, sub_in);
            m_left = WIDTH;
        end
    end

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_in_ready", 32'(in_ready), 32'(m_left == 0 && !m_done));
            check("cyc_busy", 32'(busy), 32'(m_left > 0));
            check("cyc_out_valid", 32'(out_valid), 32'(m_done));
            if (m_done) begin
                check("cyc_sum", 32'(sum), 32'(m_sum));
                check("cyc_c_out", 32'(c_out), 32'(m_cout));
            end
        end
    end

    // Present one operand set; returns at the negedge just after acceptance.
    task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                 input logic tc, input logic ts);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("in_ready_timeout", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb;
        c_in     = tc;
        sub_in   = ts;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait for the result (bounded), check latency and value, optionally
    // release it with a one-cycle out_ready pulse.
    task automatic checkOutput(input string name, input logic [WIDTH-1:0] exp_sum,
                               input logic exp_cout, input bit release_it);
        int cycles = 0;
        while (!out_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        check({name, "_latency"}, 32'(cycles), 32'(WIDTH));
        check({name, "_sum"}, 32'(sum), 32'(exp_sum));
        check({name, "_c_out"}, 32'(c_out), 32'(exp_cout));
        if (release_it) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rc;
        logic [WIDTH:0]   rexp;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Directed vectors
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("zero", 8'h00, 1'b0, 1'b1);
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
        checkOutput("ripple", 8'h00, 1'b1, 1'b1);
        applyStimulus(8'hA5, 8'h5A, 1'b1, 1'b0);
        checkOutput("a5_5a_c1", 8'h00, 1'b1, 1'b1);

        // Backpressure: result held, new operands offered but not taken
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
        checkOutput("bp_first", 8'h46, 1'b0, 1'b0);
        a        = 8'h33;
        b        = 8'h44;
        c_in     = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_sum", 32'(sum), 32'h46);
            check("bp_hold_c_out", 32'(c_out), 32'd0);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        check("bp_idle_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_taken_busy", 32'(busy), 32'd1);
        checkOutput("bp_second", 8'h78, 1'b0, 1'b1);

        // Asynchronous reset in the middle of RUN
        applyStimulus(8'h55, 8'h66, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sum", 32'(sum), 32'd0);
        check("arst_c_out", 32'(c_out), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("arst_no_valid", 32'(out_valid), 32'd0);
            check("arst_ready_after", 32'(in_ready), 32'd1);
        end
        applyStimulus(8'h10, 8'h20, 1'b0, 1'b0);
        checkOutput("after_rst", 8'h30, 1'b0, 1'b1);

`ifdef SERIAL_ADDER_SUB_EN
        // Subtract mode: c_in ignored, c_out=1 means no borrow
        applyStimulus(8'h05, 8'h07, 1'b1, 1'b1);
        checkOutput("sub_borrow", 8'hFE, 1'b0, 1'b1);
        applyStimulus(8'h07, 8'h05, 1'b1, 1'b1);
        checkOutput("sub_noborrow", 8'h02, 1'b1, 1'b1);
`endif

        // Random sweep against plain integer addition
        for (int i = 0; i < 500; i++) begin
            ra   = WIDTH'($urandom);
            rb   = WIDTH'($urandom);
            rc   = 1'($urandom_range(1, 0));
            rexp = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
            applyStimulus(ra, rb, rc, 1'b0);
            checkOutput("rand", rexp[WIDTH-1:0], rexp[WIDTH], 1'b1);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_serial_adder
